bsg_counter_one_hot_decode: RTL

Consumer side of the one-hot counter interface. It accepts one-hot count snapshots, for example from a one-hot up/clear counter, over a valid/ready handshake. It checks each snapshot for legal one-hot encoding, converts it to a binary index, and flags wrap-around from the top index to 0. Results leave through a 2-entry output buffer on a valid/yumi handshake, so `ready_o` never depends combinationally on `yumi_i`.

---
 rtl/bsg_counter_one_hot_decode.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bsg_counter_one_hot_decode.sv
// ---------------------------------------------------------------------------
// bsg_counter_one_hot_decode
//
// Consumer side of a one-hot counter link. Each accepted snapshot is checked
// for legal one-hot encoding and decoded to a binary index. The decoder also
// flags a wrap from the top index back to 0. Results queue in a 2-entry
// buffer. Because the buffer is two deep, ready_o comes from a register and
// never depends combinationally on yumi_i.
//
// Ports:
//   clk_i         rising-edge clock
//   reset_n_i     asynchronous active-low reset
//   v_i           input snapshot valid
//   one_hot_i     one-hot count snapshot [width_p]
//   ready_o       buffer can accept; a beat transfers on v_i & ready_o
//   v_o           head-of-buffer result valid
//   count_o       decoded index of the head entry [lg_width_lp]
//   err_o         head entry came from an illegal (not one-hot) snapshot
//   wrap_o        head entry is index 0 following an accepted top index
//   yumi_i        consumer takes the head (only while v_o)
//   clear_err_i   clears sticky_err_o
//   sticky_err_o  set by any accepted illegal beat, held until cleared
// ---------------------------------------------------------------------------
module bsg_counter_one_hot_decode #(
    parameter  int width_p     = 17,
    localparam int lg_width_lp = $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     one_hot_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [lg_width_lp-1:0] count_o,
    output logic                   err_o,
    output logic                   wrap_o,
    input  logic                   yumi_i,
    input  logic                   clear_err_i,
    output logic                   sticky_err_o
);

    localparam logic [1:0] occ_empty = 2'd0;
    localparam logic [1:0] occ_one   = 2'd1;
    localparam logic [1:0] occ_full  = 2'd2;

    localparam logic [lg_width_lp-1:0] top_idx_lp = lg_width_lp'(width_p - 1);

    typedef struct packed {
        logic [lg_width_lp-1:0] count;
        logic                   err;
        logic                   wrap;
    } entry_t;

    logic [1:0]             occ_r, occ_n;
    logic                   ready_r, v_r;
    entry_t                 head_r, tail_r, new_entry;
    logic [lg_width_lp-1:0] low_idx;
    logic                   is_legal;
    logic [lg_width_lp-1:0] last_idx_r;
    logic                   last_v_r;
    logic                   sticky_r;
    logic                   enq, deq;

    assign enq = v_i & ready_r;
    // A yumi with nothing to take is a protocol error; it must not move state.
    assign deq = yumi_i & v_r;

    // Decode: lowest set bit wins, so an illegal multi-hot snapshot still
    // reports a deterministic index. The descending loop lets the lowest
    // set bit be the last assignment.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        low_idx = '0;
        for (int i = width_p - 1; i >= 0; i--) begin
            if (one_hot_i[i]) begin
                low_idx = lg_width_lp'(i);
            end
        end
        // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
        is_legal = (one_hot_i != '0) &&
                   ((one_hot_i & (one_hot_i - width_p'(1))) == '0);

        new_entry.count = low_idx;
        new_entry.err   = ~is_legal;
        new_entry.wrap  = is_legal && (low_idx == '0) &&
                          last_v_r && (last_idx_r == top_idx_lp);
    end

    always_comb begin
        occ_n = occ_r;
        case (occ_r)
            occ_empty: if (enq) occ_n = occ_one;
            occ_one: begin
                if (enq && !deq)      occ_n = occ_full;
                else if (deq && !enq) occ_n = occ_empty;
            end
            occ_full:  if (deq) occ_n = occ_one;
            default:   occ_n = occ_empty;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ_r      <= occ_empty;
            ready_r    <= 1'b1;
            v_r        <= 1'b0;
            head_r     <= '0;
            last_idx_r <= '0;
            last_v_r   <= 1'b0;
            sticky_r   <= 1'b0;
        end else begin
            occ_r   <= occ_n;
            ready_r <= (occ_n != occ_full);
            v_r     <= (occ_n != occ_empty);

            // Head takes the new beat when it lands on an empty slot or when
            // the single entry leaves on the same edge; otherwise it is
            // refilled from the tail as the tail's entry moves up.
            if (enq && ((occ_r == occ_empty) || ((occ_r == occ_one) && deq))) begin
                head_r <= new_entry;
            end else if (deq && (occ_r == occ_full)) begin
                head_r <= tail_r;
            end

            // Wrap is judged in acceptance order, so the tracker follows
            // accepted legal beats, not dequeues.
            if (enq && is_legal) begin
                last_idx_r <= low_idx;
                last_v_r   <= 1'b1;
            end

            // Setting wins over a same-cycle clear.
            if (enq && !is_legal) begin
                sticky_r <= 1'b1;
            end else if (clear_err_i) begin
                sticky_r <= 1'b0;
            end
        end
    end

    // NOTE: the tail slot is plain storage with no reset. The occupancy state
    // says whether it holds anything, so its contents are irrelevant after reset.
    always_ff @(posedge clk_i) begin
        if (enq && (occ_r == occ_one) && !deq) begin
            tail_r <= new_entry;
        end
    end

    assign ready_o      = ready_r;
    assign v_o          = v_r;
    assign count_o      = head_r.count;
    assign err_o        = head_r.err;
    assign wrap_o       = head_r.wrap;
    assign sticky_err_o = sticky_r;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       yumi_i |-> v_r);

endmodule
